mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Operand source for the MAC datapath sequencer. Holds one D-element input vector and a Q×D weight matrix, loaded by the host while idle. Once a pass is started, answers each `fetch` request from the sequencer with the next (x, weight) pair one cycle later. Also flags the last element of each neuron and the last neuron of the pass, so the sequencer can close its accumulate and result loops.

## Interface
- `N`, 8: operand width in bits.
- `D`, 4: vector length, i.e. elements per neuron; D ≥ 2.
- `Q`, 3: neuron count, i.e. weight rows; Q ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `load_en` in 1: host write strobe.
- `load_sel` in 1: 0 writes the x vector, 1 writes the weight matrix.
- `load_addr` in clog2(Q*D): element index. x uses bits for 0..D-1; weights use row*D + col.
- `load_data` in N: write data.
- `start` in 1: begin a pass.
- `fetch` in 1: one-cycle request from the sequencer for the next operand pair.
- `x` out N: current input element.
- `weight` out N: current weight element.
- `operand_valid` out 1: `x`/`weight` are valid this cycle.
- `last_elem` out 1: qualified by `operand_valid`; element index == D-1.
- `last_neuron` out 1: qualified by `operand_valid`; neuron index == Q-1.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse at end of pass.
- `err` out 1: sticky protocol-error flag.

## Operation
- States:
  - IDLE: loads accepted; `start` → ARMED, with elem_idx=0 and neur_idx=0.
  - ARMED: `fetch` → ISSUE; memory read issued at (neur_idx, elem_idx).
  - ISSUE: `operand_valid`=1.
    - Not last element: elem_idx++ and → ARMED.
    - Last element of a non-last neuron: elem_idx wraps to 0, neur_idx++, → ARMED.
    - Last element of last neuron: → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Loads:
  - Write on `load_en` only in IDLE.
  - `load_en` in any other state is ignored and sets `err`.
  - A `load_addr` beyond range (x: ≥ D; weight: ≥ Q*D) is ignored and sets `err`.
- `fetch` in IDLE, ISSUE or DONE: ignored, sets `err`.
- `start` outside IDLE: ignored, no error.
- Simultaneous `load_en` and `start` in IDLE: the write completes and the pass starts. The first read occurs at least one cycle later, so it sees the new data.
- Memory contents are not cleared by `rst`. Reloading is the host's responsibility.
- `err` clears only on `rst`.
- Reset values: all outputs 0; state IDLE; indices 0.
- `rst` mid-pass aborts the pass immediately:
  - no `done` pulse;
  - the next cycle is IDLE with outputs 0.

## Timing
- Fetch latency 1: `fetch` sampled high at edge t (state ARMED) → `operand_valid`, `x`, `weight` and flags valid during cycle t+1.
- Minimum fetch spacing is 2 cycles: ARMED → ISSUE → ARMED.
- A full pass takes exactly Q*D accepted fetches.
- `done` asserts the cycle after the final ISSUE.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- Loads write on the edge they are sampled.

## Configuration
- `FEEDER_ERR_EN`
  - Defined: protocol-error detection and the sticky `err` flag operate as described.
  - Undefined: no detection logic is built and `err` is tied 0. Illegal loads, fetches and out-of-range addresses are still ignored.

## Structure
- Package `mac_pkg` holds:
  - the feeder state enum (IDLE, ARMED, ISSUE, DONE);
  - index-width constants derived from D and Q via clog2;
  - the `load_sel` encodings.
- Sub-module `feeder_mem`: dual-array storage, with D×N bits for x and Q*D×N bits for weights.
  - Synchronous write and registered read.
  - The registered read provides the 1-cycle fetch latency.

## Test plan
- Load x={1,2,3,4} and W rows {5,6,7,8},{9,10,11,12},{13,14,15,16}; start; issue fetches every 2 cycles → 12 valid pairs (1,5),(2,6)…(4,16). `last_elem` on pairs 4/8/12, `last_neuron` on pairs 9–12, `done` one cycle after pair 12, `err`=0.
- Fetches spaced 5 cycles apart → same pair sequence; `operand_valid` exactly 1 cycle after each fetch.
- `load_en` with data 0xFF during ARMED → memory unchanged, `err`=1 (macro defined) or 0 (undefined).
- Fetch while in ISSUE (back-to-back cycles) → second fetch ignored, index advances once, `err`=1.
- Assert `rst` after pair 6 → IDLE next cycle, all outputs 0, no `done`. Restart without reloading → pass begins again at (1,5).
- `load_en`+`start` same cycle, writing x[0]=42 → first pair is (42,5).

Source files
------------

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC operand feeder:
//   - default geometry (operand width, vector length, neuron count)
//   - index / address width helper and derived width constants
//   - feeder FSM state encoding
//   - load_sel encodings (x vector vs weight matrix)
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int FEEDER_N = 8;
    localparam int FEEDER_D = 4;
    localparam int FEEDER_Q = 3;

    // Width of an index able to address 'count' entries; never below 1 bit so
    // that a single-entry dimension still has a legal vector type.
    function automatic int idx_w(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int ELEM_W = idx_w(FEEDER_D);
    localparam int NEUR_W = idx_w(FEEDER_Q);
    localparam int ADDR_W = idx_w(FEEDER_Q * FEEDER_D);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_t;

    localparam logic LOAD_SEL_X = 1'b0;
    localparam logic LOAD_SEL_W = 1'b1;

endpackage : mac_pkg

// File: rtl/mac_operand_feeder_if.sv
// -----------------------------------------------------------------------------
// mac_operand_feeder_if
// Bundles the host load bus, the sequencer fetch handshake and the operand /
// status outputs of the feeder.
//   Host load bus : load_en, load_sel, load_addr, load_data, start
//   Sequencer     : fetch (request) -> operand_valid, x, weight,
//                   last_elem, last_neuron (one cycle later)
//   Status        : busy, done, err
// Handshake: fetch is a single-cycle request; it is only accepted while the
// feeder is ARMED, and the matching operand pair is presented with
// operand_valid high during exactly the following cycle. There is no
// back-pressure on the operand side; last_elem/last_neuron are meaningful only
// while operand_valid is high.
// Modports: slave = feeder side, master = host/sequencer side.
// -----------------------------------------------------------------------------
interface mac_operand_feeder_if #(
    parameter int N = mac_pkg::FEEDER_N,
    parameter int D = mac_pkg::FEEDER_D,
    parameter int Q = mac_pkg::FEEDER_Q
);
    localparam int AW = mac_pkg::idx_w(Q * D);

    logic          load_en;
    logic          load_sel;
    logic [AW-1:0] load_addr;
    logic [N-1:0]  load_data;
    logic          start;
    logic          fetch;
    logic [N-1:0]  x;
    logic [N-1:0]  weight;
    logic          operand_valid;
    logic          last_elem;
    logic          last_neuron;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  load_en, load_sel, load_addr, load_data, start, fetch,
        output x, weight, operand_valid, last_elem, last_neuron,
        output busy, done, err
    );

    modport master (
        output load_en, load_sel, load_addr, load_data, start, fetch,
        input  x, weight, operand_valid, last_elem, last_neuron,
        input  busy, done, err
    );

endinterface : mac_operand_feeder_if

// File: rtl/mac_operand_feeder_mem.sv
// -----------------------------------------------------------------------------
// feeder_mem
// Dual-array operand storage: D x N bits for the input vector and Q*D x N bits
// for the weight matrix. Synchronous write, registered read. The registered
// read is what gives the feeder its one-cycle fetch latency. Contents are not
// reset.
// Ports:
//   i_clk                     clock
//   i_wr_x_en / i_wr_w_en     write strobes (address already range-checked)
//   i_wr_addr, i_wr_data      write address / data
//   i_rd_en                   capture read data this edge
//   i_rd_x_addr, i_rd_w_addr  read addresses
//   o_rd_x, o_rd_w            registered read data
// -----------------------------------------------------------------------------
module feeder_mem #(
    parameter int N  = 8,
    parameter int D  = 4,
    parameter int Q  = 3,
    parameter int AW = 4,
    parameter int EW = 2
) (
    input  logic          i_clk,
    input  logic          i_wr_x_en,
    input  logic          i_wr_w_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [N-1:0]  i_wr_data,
    input  logic          i_rd_en,
    input  logic [EW-1:0] i_rd_x_addr,
    input  logic [AW-1:0] i_rd_w_addr,
    output logic [N-1:0]  o_rd_x,
    output logic [N-1:0]  o_rd_w
);

    logic [N-1:0] r_x_mem [0:D-1];
    logic [N-1:0] r_w_mem [0:Q*D-1];
    logic [N-1:0] r_rd_x;
    logic [N-1:0] r_rd_w;
    logic [EW-1:0] w_wr_x_addr;

    assign w_wr_x_addr = i_wr_addr[EW-1:0];

    always_ff @(posedge i_clk) begin
        if (i_wr_x_en) begin
            r_x_mem[w_wr_x_addr] <= i_wr_data;
        end
        if (i_wr_w_en) begin
            r_w_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_x <= r_x_mem[i_rd_x_addr];
            r_rd_w <= r_w_mem[i_rd_w_addr];
        end
    end

    assign o_rd_x = r_rd_x;
    assign o_rd_w = r_rd_w;

endmodule : feeder_mem

// File: rtl/mac_operand_feeder.sv
// -----------------------------------------------------------------------------
// mac_operand_feeder
// Operand source for the MAC datapath sequencer. The host loads an input
// vector (D elements) and a Q x D weight matrix while idle, then starts a
// pass. Each accepted fetch returns the next (x, weight) pair one cycle
// later, walking elements within a neuron, then neurons, and flags the last
// element of each neuron and the last neuron of the pass.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   bus            mac_operand_feeder_if.slave (load bus, fetch, operands,
//                  busy/done/err)
//   o_dbg_state    current FSM state
// Optional build macro: FEEDER_ERR_EN builds protocol-error detection and the
// sticky err flag; without it err is tied low (illegal requests are still
// ignored).
// -----------------------------------------------------------------------------
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int N = FEEDER_N,
    parameter int D = FEEDER_D,
    parameter int Q = FEEDER_Q
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mac_operand_feeder_if.slave   bus,
    output feeder_state_t         o_dbg_state
);

    localparam int AW = idx_w(Q * D);
    localparam int EW = idx_w(D);
    localparam int QW = idx_w(Q);

    // One extra bit so a limit of exactly 2**AW is representable.
    localparam logic [AW:0] X_LIMIT = (AW + 1)'(D);
    localparam logic [AW:0] W_LIMIT = (AW + 1)'(Q * D);
    localparam logic [EW-1:0] ELEM_LAST = EW'(D - 1);
    localparam logic [QW-1:0] NEUR_LAST = QW'(Q - 1);

    feeder_state_t r_state;
    feeder_state_t w_next_state;
    logic [EW-1:0] r_elem_idx;
    logic [QW-1:0] r_neur_idx;

    logic          w_in_idle;
    logic          w_in_issue;
    logic          w_addr_ok;
    logic          w_wr_x;
    logic          w_wr_w;
    logic          w_fetch_ok;
    logic          w_last_elem;
    logic          w_last_neur;
    logic [AW-1:0] w_rd_w_addr;
    logic [N-1:0]  w_rd_x;
    logic [N-1:0]  w_rd_w;

    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_in_issue = (r_state == ST_ISSUE);

    assign w_addr_ok = (bus.load_sel == LOAD_SEL_X) ? ({1'b0, bus.load_addr} < X_LIMIT)
                                                    : ({1'b0, bus.load_addr} < W_LIMIT);

    assign w_wr_x = bus.load_en && w_in_idle && w_addr_ok && (bus.load_sel == LOAD_SEL_X);
    assign w_wr_w = bus.load_en && w_in_idle && w_addr_ok && (bus.load_sel == LOAD_SEL_W);

    assign w_fetch_ok  = bus.fetch && (r_state == ST_ARMED);
    assign w_last_elem = (r_elem_idx == ELEM_LAST);
    assign w_last_neur = (r_neur_idx == NEUR_LAST);

    // Row-major weight address: row = neuron, column = element.
    assign w_rd_w_addr = AW'(r_neur_idx) * AW'(D) + AW'(r_elem_idx);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.fetch) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_last_elem && w_last_neur) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Indices hold the coordinates of the pair being presented during ISSUE
    // and advance on the way out of ISSUE, ready for the next fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_elem_idx <= '0;
            r_neur_idx <= '0;
        end else if (w_in_idle && bus.start) begin
            r_elem_idx <= '0;
            r_neur_idx <= '0;
        end else if (w_in_issue) begin
            if (!w_last_elem) begin
                r_elem_idx <= r_elem_idx + 1'b1;
            end else begin
                r_elem_idx <= '0;
                if (!w_last_neur) begin
                    r_neur_idx <= r_neur_idx + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------- storage
    feeder_mem #(
        .N  (N),
        .D  (D),
        .Q  (Q),
        .AW (AW),
        .EW (EW)
    ) u_mem (
        .i_clk       (i_clk),
        .i_wr_x_en   (w_wr_x),
        .i_wr_w_en   (w_wr_w),
        .i_wr_addr   (bus.load_addr),
        .i_wr_data   (bus.load_data),
        .i_rd_en     (w_fetch_ok),
        .i_rd_x_addr (r_elem_idx),
        .i_rd_w_addr (w_rd_w_addr),
        .o_rd_x      (w_rd_x),
        .o_rd_w      (w_rd_w)
    );

    // ------------------------------------------------------------- outputs
    // Operand data is forced to zero outside ISSUE so the outputs are clean
    // after reset even though the memory and read registers are not reset.
    assign bus.operand_valid = w_in_issue;
    assign bus.x             = w_in_issue ? w_rd_x : '0;
    assign bus.weight        = w_in_issue ? w_rd_w : '0;
    assign bus.last_elem     = w_in_issue && w_last_elem;
    assign bus.last_neuron   = w_in_issue && w_last_neur;
    assign bus.busy          = !w_in_idle;
    assign bus.done          = (r_state == ST_DONE);
    assign o_dbg_state       = r_state;

`ifdef FEEDER_ERR_EN
    logic r_err;
    logic w_err_evt;

    // Loads outside IDLE, out-of-range load addresses, and fetches in any
    // state but ARMED are protocol errors.
    assign w_err_evt = (bus.load_en && (!w_in_idle || !w_addr_ok))
                     || (bus.fetch && (r_state != ST_ARMED));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule : mac_operand_feeder

// File: tb/tb_mac_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_operand_feeder
// Directed bench for mac_operand_feeder with D=4, Q=3, N=8.
// -----------------------------------------------------------------------------
module tb_mac_operand_feeder;
    import mac_pkg::*;

    localparam int N = 8;
    localparam int D = 4;
    localparam int Q = 3;
    localparam int NP = Q * D;

    logic          clk;
    logic          rst;
    feeder_state_t dbg_state;

    int n_checks;
    int n_fail;

    logic [N-1:0] xm [D];
    logic [N-1:0] wm [NP];
    logic         exp_err;
    logic         err_on;

    mac_operand_feeder_if #(.N(N), .D(D), .Q(Q)) bus_if ();

    mac_operand_feeder #(.N(N), .D(D), .Q(Q)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus_if.slave),
        .o_dbg_state (dbg_state)
    );

    // ------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ checker
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_valid"}, 32'(bus_if.operand_valid), 32'd0);
        check_val({tag, "_x"}, 32'(bus_if.x), 32'd0);
        check_val({tag, "_w"}, 32'(bus_if.weight), 32'd0);
        check_val({tag, "_le"}, 32'(bus_if.last_elem), 32'd0);
        check_val({tag, "_ln"}, 32'(bus_if.last_neuron), 32'd0);
        check_val({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        check_val({tag, "_done"}, 32'(bus_if.done), 32'd0);
        check_val({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Host write while idle; the model mirrors only in-range writes.
    task automatic load_word(input logic sel, input int addr, input logic [N-1:0] data);
        bus_if.load_en   = 1'b1;
        bus_if.load_sel  = sel;
        bus_if.load_addr = 4'(addr);
        bus_if.load_data = data;
        tick();
        bus_if.load_en = 1'b0;
        if (sel == LOAD_SEL_X && addr < D) xm[addr] = data;
        if (sel == LOAD_SEL_W && addr < NP) wm[addr] = data;
    endtask

    task automatic start_pass();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        check_val("start_busy", 32'(bus_if.busy), 32'd1);
        check_val("start_state", 32'(dbg_state), 32'(ST_ARMED));
    endtask

    // One fetch; the pair for pass index k is checked in the following cycle.
    task automatic fetch_pair(input int k);
        bus_if.fetch = 1'b1;
        tick();
        bus_if.fetch = 1'b0;
        check_val($sformatf("p%0d_valid", k), 32'(bus_if.operand_valid), 32'd1);
        check_val($sformatf("p%0d_x", k), 32'(bus_if.x), 32'(xm[k % D]));
        check_val($sformatf("p%0d_w", k), 32'(bus_if.weight), 32'(wm[k]));
        check_val($sformatf("p%0d_le", k), 32'(bus_if.last_elem), 32'((k % D) == D - 1));
        check_val($sformatf("p%0d_ln", k), 32'(bus_if.last_neuron), 32'(k >= (Q - 1) * D));
        check_val($sformatf("p%0d_done", k), 32'(bus_if.done), 32'd0);
        check_val($sformatf("p%0d_err", k), 32'(bus_if.err), 32'(exp_err));
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_val("gap_valid", 32'(bus_if.operand_valid), 32'd0);
            check_val("gap_done", 32'(bus_if.done), 32'd0);
        end
    endtask

    task automatic run_pass(input int gap, input int first);
        for (int k = first; k < NP; k++) begin
            fetch_pair(k);
            if (k < NP - 1) idle_gap(gap - 1);
        end
        tick();
        check_val("end_done", 32'(bus_if.done), 32'd1);
        check_val("end_busy", 32'(bus_if.busy), 32'd1);
        check_val("end_valid", 32'(bus_if.operand_valid), 32'd0);
        tick();
        check_val("post_done", 32'(bus_if.done), 32'd0);
        check_val("post_busy", 32'(bus_if.busy), 32'd0);
        check_val("post_state", 32'(dbg_state), 32'(ST_IDLE));
        check_val("post_err", 32'(bus_if.err), 32'(exp_err));
    endtask

    // ---------------------------------------------------------- main flow
    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_err  = 1'b0;
`ifdef FEEDER_ERR_EN
        err_on = 1'b1;
`else
        err_on = 1'b0;
`endif
        rst              = 1'b1;
        bus_if.load_en   = 1'b0;
        bus_if.load_sel  = 1'b0;
        bus_if.load_addr = '0;
        bus_if.load_data = '0;
        bus_if.start     = 1'b0;
        bus_if.fetch     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_quiet("rst");
        check_val("rst_err", 32'(bus_if.err), 32'd0);

        // Load x = {1,2,3,4}, W rows {5..8},{9..12},{13..16}.
        for (int i = 0; i < D; i++) load_word(LOAD_SEL_X, i, 8'(i + 1));
        for (int i = 0; i < NP; i++) load_word(LOAD_SEL_W, i, 8'(i + 5));

        // Pass with fetches every 2 cycles.
        start_pass();
        run_pass(2, 0);

        // Pass with fetches every 5 cycles.
        start_pass();
        run_pass(5, 0);

        // Out-of-range x address while idle: ignored, err if detection built.
        load_word(LOAD_SEL_X, 4, 8'hEE);
        exp_err = err_on;
        check_val("oor_err", 32'(bus_if.err), 32'(exp_err));

        // Load during ARMED: ignored; the pass still sees W[0]=5.
        start_pass();
        bus_if.load_en   = 1'b1;
        bus_if.load_sel  = LOAD_SEL_W;
        bus_if.load_addr = 4'd0;
        bus_if.load_data = 8'hFF;
        tick();
        bus_if.load_en = 1'b0;
        check_val("armload_err", 32'(bus_if.err), 32'(exp_err));
        check_val("armload_state", 32'(dbg_state), 32'(ST_ARMED));
        run_pass(2, 0);

        // Clear err, then fetch held across ISSUE: second fetch ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        check_val("clr_err", 32'(bus_if.err), 32'd0);
        start_pass();
        bus_if.fetch = 1'b1;
        tick();
        check_val("b2b_valid0", 32'(bus_if.operand_valid), 32'd1);
        check_val("b2b_x0", 32'(bus_if.x), 32'd1);
        check_val("b2b_w0", 32'(bus_if.weight), 32'd5);
        tick();
        bus_if.fetch = 1'b0;
        exp_err = err_on;
        check_val("b2b_valid1", 32'(bus_if.operand_valid), 32'd0);
        check_val("b2b_state", 32'(dbg_state), 32'(ST_ARMED));
        check_val("b2b_err", 32'(bus_if.err), 32'(exp_err));
        run_pass(2, 1);

        // Reset after pair 6 aborts the pass; restart begins at (1,5).
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        start_pass();
        for (int k = 0; k < 6; k++) begin
            fetch_pair(k);
            idle_gap(1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("abort");
        tick();
        check_quiet("abort2");
        start_pass();
        run_pass(2, 0);

        // Load and start in the same cycle: first pair is (42,5).
        bus_if.load_en   = 1'b1;
        bus_if.load_sel  = LOAD_SEL_X;
        bus_if.load_addr = 4'd0;
        bus_if.load_data = 8'd42;
        bus_if.start     = 1'b1;
        tick();
        bus_if.load_en = 1'b0;
        bus_if.start   = 1'b0;
        xm[0] = 8'd42;
        check_val("ls_busy", 32'(bus_if.busy), 32'd1);
        check_val("ls_state", 32'(dbg_state), 32'(ST_ARMED));
        run_pass(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mac_operand_feeder
